// File: rtl/tile_burst_req_gen.sv
// Splits one tile-region command into bus-aligned read bursts
// (max length, no boundary crossing, capped in-flight count).
// Ports: clk, rst_n | cmd_valid/cmd_ready/cmd_base_addr/cmd_length_bytes
//        req_valid/req_ready/req_addr/req_beats | resp_done | busy, done, err
module tile_burst_req_gen #(
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 32,
  parameter int BUS_BYTES       = 16,
  parameter int MAX_BURST_BEATS = 16,
  parameter int BOUNDARY_BYTES  = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_length_bytes,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  output logic [8:0]            req_beats,
  input  logic                  resp_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int OFF_W     = $clog2(BUS_BYTES);
  localparam int BW        = LEN_WIDTH + 1;
  localparam int OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int BND_BEATS = BOUNDARY_BYTES / BUS_BYTES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BW-1:0]         r_rem;
  logic [OW-1:0]         r_out;
  logic [OW-1:0]         w_out_nxt;
  logic                  w_acc;
  logic                  w_hs;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] w_base_al;
  logic [BW-1:0]         w_total;
  logic [BW-1:0]         w_bnd;
  logic [BW-1:0]         w_size;

  assign w_acc     = cmd_valid && cmd_ready;
  assign w_hs      = req_valid && req_ready;
  assign w_base_al = cmd_base_addr & ~ADDR_WIDTH'(BUS_BYTES - 1);

  // beat count includes the unaligned head bytes
  assign w_total =
    (BW'(cmd_length_bytes)
     + BW'(cmd_base_addr & ADDR_WIDTH'(BUS_BYTES - 1))
     + BW'(BUS_BYTES - 1)) >> OFF_W;

  // beats left before the next boundary line
  assign w_bnd =
    BW'(BND_BEATS)
    - BW'((r_addr & ADDR_WIDTH'(BOUNDARY_BYTES - 1)) >> OFF_W);

  always_comb begin
    w_size = r_rem;
    if (w_size > BW'(MAX_BURST_BEATS))
      w_size = BW'(MAX_BURST_BEATS);
    if (w_size > w_bnd)
      w_size = w_bnd;
  end

  // simultaneous issue and completion cancel out
  always_comb begin
    w_out_nxt = r_out;
    if (w_hs && !resp_done)
      w_out_nxt = r_out + OW'(1);
    else if (!w_hs && resp_done && r_out != '0)
      w_out_nxt = r_out - OW'(1);
  end

  // next burst is staged using the post-edge in-flight count,
  // which also allows back-to-back bursts after a handshake
  assign w_load = (r_state == S_ISSUE)
               && (!req_valid || w_hs)
               && (r_rem != '0)
               && (w_out_nxt < OW'(MAX_OUTSTANDING));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc)
          w_state_nxt = (cmd_length_bytes == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_hs && r_rem == '0)
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_out_nxt == '0)
          w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_rem     <= '0;
      r_out     <= '0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_beats <= '0;
      err       <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      if (resp_done && r_out == '0)
        err <= 1'b1;
      else if (w_acc)
        err <= 1'b0;
      if (w_acc) begin
        r_addr <= w_base_al;
        r_rem  <= w_total;
      end else if (w_load) begin
        r_addr <= r_addr + (ADDR_WIDTH'(w_size) << OFF_W);
        r_rem  <= r_rem - w_size;
      end
      if (w_load) begin
        req_valid <= 1'b1;
        req_addr  <= r_addr;
        req_beats <= 9'(w_size);
      end else if (w_hs) begin
        req_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tile_burst_req_gen.sv
// Scoreboard bench for tile_burst_req_gen: expected bursts queued
// at command time, popped on each request handshake.
`timescale 1ns/1ps
module tb_tile_burst_req_gen;

  typedef struct {
    logic [31:0] a;
    logic [8:0]  b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_base_addr = '0;
  logic [31:0] cmd_length_bytes = '0;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [8:0]  req_beats;
  logic        resp_done;
  logic        busy;
  logic        done;
  logic        err;

  logic man_rdy = 1'b0;
  logic rnd_rdy = 1'b0;
  logic rnd_en  = 1'b0;
  logic mresp   = 1'b0;
  logic aresp   = 1'b0;
  logic auto_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int resp_cnt = 0;
  int done_cnt = 0;
  int lost    = 0;

  exp_t exp_q[$];

  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_a = '0;
  logic [8:0]  prev_b = '0;

  assign req_ready = rnd_en ? rnd_rdy : man_rdy;
  assign resp_done = mresp | aresp;

  tile_burst_req_gen dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_base_addr    (cmd_base_addr),
    .cmd_length_bytes (cmd_length_bytes),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_beats        (req_beats),
    .resp_done        (resp_done),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // byte-domain split: stop at 256 bytes, the next 4 KiB line,
  // or the rounded-up region end, whichever is first
  task automatic model_push(input longint base, input longint len,
                            output int n);
    longint a, e, lim, bnd;
    n = 0;
    a = base & ~64'hF;
    e = (base + len + 15) & ~64'hF;
    while (a < e) begin
      bnd = (a | 64'hFFF) + 1;
      lim = a + 256;
      if (bnd < lim) lim = bnd;
      if (e < lim) lim = e;
      exp_q.push_back('{a[31:0], 9'((lim - a) / 16)});
      n++;
      a = lim;
    end
  endtask

  // monitor: sampled mid-cycle, inputs settle at posedge+1
  always @(negedge clk) begin
    if (rst_n && req_valid && req_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("req_extra", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("req_addr", 64'(req_addr), 64'(e.a));
        chk("req_beats", 64'(req_beats), 64'(e.b));
      end
    end
    if (rst_n && prev_v && !prev_r)
      chk("req_hold", {22'd0, req_valid, req_addr, req_beats},
          {22'd0, 1'b1, prev_a, prev_b});
    if (resp_done) resp_cnt++;
    if (done) done_cnt++;
    prev_v = req_valid && rst_n;
    prev_r = req_ready;
    prev_a = req_addr;
    prev_b = req_beats;
  end

  // random ready and in-order responder
  initial forever begin
    @(posedge clk);
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
    if (auto_en && (hs_cnt - resp_cnt - lost) > 0
        && $urandom_range(0, 2) == 0)
      aresp = 1'b1;
    else
      aresp = 1'b0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench stalled");
    $fatal(1);
  end

  task automatic send_cmd(input logic [31:0] base,
                          input logic [31:0] len);
    @(posedge clk);
    #1;
    cmd_valid        = 1'b1;
    cmd_base_addr    = base;
    cmd_length_bytes = len;
    @(negedge clk);
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] base,
                         input logic [31:0] len);
    int n, h0, d0, k;
    model_push(longint'(base), longint'(len), n);
    h0 = hs_cnt;
    d0 = done_cnt;
    send_cmd(base, len);
    k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(done_cnt - d0), 64'd1);
    chk("bursts", 64'(hs_cnt - h0), 64'(n));
    chk("sb_left", 64'(exp_q.size()), 64'd0);
    chk("err_run", 64'(err), 64'd0);
  endtask

  initial begin
    int n, h0;
    // reset state
    #3;
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_addr", 64'(req_addr), 64'd0);
    chk("rst_beats", 64'(req_beats), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    #20;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 64'(cmd_ready), 64'd1);

    // aligned single burst, latency and done timing
    man_rdy = 1'b1;
    model_push(64'h1000, 64'd256, n);
    send_cmd(32'h1000, 32'd256);
    @(negedge clk);
    chk("lat0", 64'(req_valid), 64'd0);
    chk("busy1", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lat1", 64'(req_valid), 64'd1);
    @(posedge clk);
    #1;
    man_rdy = 1'b0;
    @(negedge clk);
    chk("one_burst", 64'(req_valid), 64'd0);
    chk("t1_drain_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    mresp = 1'b1;
    @(posedge clk);
    #1;
    mresp = 1'b0;
    @(negedge clk);
    chk("t1_done", 64'(done), 64'd1);
    @(negedge clk);
    chk("t1_done_end", 64'(done), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // boundary split, unaligned, random traffic
    rnd_en  = 1'b1;
    auto_en = 1'b1;
    run_cmd(32'h0FF0, 32'd64);
    run_cmd(32'h2008, 32'd16);
    run_cmd(32'h0F08, 32'd5000);
    for (int i = 0; i < 3; i++)
      run_cmd($urandom_range(0, 32'hFFFF), $urandom_range(1, 3000));
    auto_en = 1'b0;
    rnd_en  = 1'b0;

    // zero length
    h0 = hs_cnt;
    send_cmd(32'h5000, 32'd0);
    @(negedge clk);
    chk("z_done", 64'(done), 64'd1);
    chk("z_busy", 64'(busy), 64'd1);
    chk("z_valid", 64'(req_valid), 64'd0);
    @(negedge clk);
    chk("z_done_end", 64'(done), 64'd0);
    chk("z_busy_end", 64'(busy), 64'd0);
    chk("z_bursts", 64'(hs_cnt - h0), 64'd0);

    // outstanding cap
    man_rdy = 1'b1;
    h0 = hs_cnt;
    model_push(64'h0, 64'd2048, n);
    send_cmd(32'h0, 32'd2048);
    for (int i = 0; i < 6; i++) @(negedge clk);
    cmd_valid        = 1'b1;
    cmd_base_addr    = 32'hBEEF0;
    cmd_length_bytes = 32'd16;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cap_valid", 64'(req_valid), 64'd0);
      chk("busy_rdy", 64'(cmd_ready), 64'd0);
    end
    cmd_valid = 1'b0;
    chk("cap4", 64'(hs_cnt - h0), 64'd4);
    @(posedge clk);
    #1;
    mresp = 1'b1;
    @(posedge clk);
    #1;
    mresp = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("cap5", 64'(hs_cnt - h0), 64'd5);
    @(posedge clk);
    #1;
    mresp = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    mresp = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("cap7", 64'(hs_cnt - h0), 64'd7);
    chk("cap7_valid", 64'(req_valid), 64'd0);
    auto_en = 1'b1;
    h0 = 0;
    while (exp_q.size() != 0 && h0 < 200) begin
      @(negedge clk);
      h0++;
    end
    chk("cap_all", 64'(exp_q.size()), 64'd0);
    h0 = done_cnt;
    for (int i = 0; i < 200 && done_cnt == h0; i++)
      @(negedge clk);
    chk("cap_done", 64'(done_cnt - h0), 64'd1);
    chk("cap_err", 64'(err), 64'd0);
    auto_en = 1'b0;

    // reset mid-issue, stray response, err cleared on accept
    model_push(64'h0, 64'd4096, n);
    send_cmd(32'h0, 32'd4096);
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(req_valid), 64'd0);
    chk("mr_addr", 64'(req_addr), 64'd0);
    chk("mr_beats", 64'(req_beats), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mresp = 1'b1;
    @(posedge clk);
    #1;
    mresp = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(err), 64'd1);
    lost = hs_cnt - resp_cnt;
    auto_en = 1'b1;
    rnd_en  = 1'b1;
    run_cmd(32'h3000, 32'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
